riscv_dmem_access: RTL

- Memory-access/writeback-register stage directly downstream of the M pipeline register.
- Consumes the M-stage control and datapath signals and performs the data-memory load/store over a req/ack bus. Aligns store data and byte enables, and sign- or zero-extends load data.
- Stalls upstream until the access completes, then loads the W pipeline register that feeds the writeback mux.
- Bounds every access with a timeout.

---
 rtl/riscv_dmem_access.sv | 114 +++++++++++
 1 files changed

// File: rtl/riscv_dmem_access.sv
// Memory-access stage: drives the data-memory req/ack bus from the M-stage
// controls, stalls upstream until the access finishes, and loads the W register.
module riscv_dmem_access #(
  parameter int XLEN      = 32,
  parameter int P_TIMEOUT = 16,
  parameter int P_TCNT_W  = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ctrl_reg_wr_enM,
  input  logic [1:0]      i_ctrl_result_srcM,
  input  logic            i_ctrl_mem_wr_enM,
  input  logic [3:0]      i_ctrl_mem_byte_selM,
  input  logic            i_ctrl_mem_signedM,
  input  logic [XLEN-1:0] i_alu_resultM,
  input  logic [XLEN-1:0] i_mem_writedataM,
  input  logic [4:0]      i_regfile_rd_addrM,
  input  logic [XLEN-1:0] i_PCPlus4M,
  input  logic [XLEN-1:0] i_PCTargetM,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall_M,
  output logic            o_misaligned,
  output logic            o_bus_err,
  output logic            o_ctrl_reg_wr_enW,
  output logic [1:0]      o_ctrl_result_srcW,
  output logic [XLEN-1:0] o_alu_resultW,
  output logic [XLEN-1:0] o_mem_readdataW,
  output logic [4:0]      o_regfile_rd_addrW,
  output logic [XLEN-1:0] o_PCPlus4W,
  output logic [XLEN-1:0] o_PCTargetW
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [P_TCNT_W-1:0] TLAST = P_TCNT_W'(P_TIMEOUT - 1);

  state_t              state, stateNext;
  logic [P_TCNT_W-1:0] tcnt;
  logic                memOp, misalign, ackV, timeout, wLoad;
  logic [1:0]          off;
  logic [XLEN-1:0]     shifted, loadExt;

  always_comb begin
    memOp    = i_ctrl_mem_wr_enM | (i_ctrl_result_srcM == 2'b01);
    off      = i_alu_resultM[1:0];
    misalign = ((i_ctrl_mem_byte_selM == 4'b0011) & off[0]) |
               ((i_ctrl_mem_byte_selM == 4'b1111) & (off != 2'b00));

    // Combinational bus outputs are gated by reset so they drop without a clock.
    o_dmem_req   = ~i_rst & memOp & ~misalign;
    o_dmem_we    = i_ctrl_mem_wr_enM;
    o_dmem_addr  = {i_alu_resultM[XLEN-1:2], 2'b00};
    o_dmem_be    = 4'(i_ctrl_mem_byte_selM << off);
    o_dmem_wdata = i_mem_writedataM << {off, 3'b000};

    ackV         = i_dmem_ack & o_dmem_req;
    timeout      = (state == WAIT) & (tcnt == TLAST) & ~ackV;
    o_bus_err    = ~i_rst & timeout;
    o_misaligned = ~i_rst & memOp & misalign & (state == IDLE);
    o_stall_M    = o_dmem_req & ~ackV & ~timeout;
    wLoad        = ~o_stall_M & ~o_misaligned & ~timeout;

    shifted = i_dmem_rdata >> {off, 3'b000};
    case (i_ctrl_mem_byte_selM)
      4'b0001: loadExt = {{(XLEN-8){i_ctrl_mem_signedM & shifted[7]}}, shifted[7:0]};
      4'b0011: loadExt = {{(XLEN-16){i_ctrl_mem_signedM & shifted[15]}}, shifted[15:0]};
      default: loadExt = shifted;
    endcase

    stateNext = state;
    case (state)
      IDLE: if (o_dmem_req & ~ackV) stateNext = WAIT;
      WAIT: if (ackV | timeout | ~o_dmem_req) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state              <= IDLE;
      tcnt               <= '0;
      o_ctrl_reg_wr_enW  <= 1'b0;
      o_ctrl_result_srcW <= '0;
      o_alu_resultW      <= '0;
      o_mem_readdataW    <= '0;
      o_regfile_rd_addrW <= '0;
      o_PCPlus4W         <= '0;
      o_PCTargetW        <= '0;
    end else begin
      state <= stateNext;
      tcnt  <= (state == WAIT) ? tcnt + 1'b1 : '0;
      // Bubble keeps the payload fields but kills the write and destination.
      if (wLoad) begin
        o_ctrl_reg_wr_enW  <= i_ctrl_reg_wr_enM;
        o_ctrl_result_srcW <= i_ctrl_result_srcM;
        o_alu_resultW      <= i_alu_resultM;
        o_mem_readdataW    <= loadExt;
        o_regfile_rd_addrW <= i_regfile_rd_addrM;
        o_PCPlus4W         <= i_PCPlus4M;
        o_PCTargetW        <= i_PCTargetM;
      end else begin
        o_ctrl_reg_wr_enW  <= 1'b0;
        o_regfile_rd_addrW <= '0;
      end
    end
  end

endmodule
